// File: rtl/data_bus_controller.sv
// MEM-stage data bus controller: turns LOAD/STORE requests into SRAM (ready handshake)
// or I/O-window (fixed wait states) transactions and stalls the pipeline until done.
module data_bus_controller #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE    = 16'h0020,
    parameter logic [ADDR_WIDTH-1:0] IO_LIMIT   = 16'h005F,
    parameter int                    IO_WAIT    = 2,
    parameter int                    TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  control_mem_read,
    input  logic                  control_mem_write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_to_store,
    output logic [DATA_WIDTH-1:0] data_loaded,
    output logic                  stall,
    output logic                  bus_error,
    output logic                  sram_cs,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    input  logic                  sram_ready,
    output logic                  io_cs,
    output logic                  io_we,
    output logic [ADDR_WIDTH-1:0] io_addr,
    output logic [DATA_WIDTH-1:0] io_wdata,
    input  logic [DATA_WIDTH-1:0] io_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SRAM_WAIT,
        S_IO_WAIT,
        S_COMPLETE
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [3:0] IO_LOAD  = 4'(IO_WAIT);

    state_t                state, next_state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  dir_q;
    logic [3:0]            io_cnt;
    logic [7:0]            tmo_cnt;

    logic req_valid, req_both, in_io, timeout_hit, next_dir, idle_req;

    assign req_valid = control_mem_read ^ control_mem_write;
    assign req_both  = control_mem_read & control_mem_write;
    assign in_io     = (address >= IO_BASE) && (address <= IO_LIMIT);
    assign idle_req  = (state == S_IDLE) && req_valid;
    assign next_dir  = idle_req ? control_mem_write : dir_q;

    // NOTE: every always_comb output gets a default first so no path leaves a latch.
    always_comb begin
        next_state  = state;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_both)
                    next_state = S_COMPLETE;
                else if (req_valid)
                    next_state = in_io ? S_IO_WAIT : S_SRAM_WAIT;
            end
            S_SRAM_WAIT: begin
                if (sram_ready) begin
                    next_state = S_COMPLETE;
                end else if (tmo_cnt == TMO_LAST) begin
                    next_state  = S_COMPLETE;
                    timeout_hit = 1'b1;
                end
            end
            S_IO_WAIT: begin
                if (io_cnt == 4'd1)
                    next_state = S_COMPLETE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Stall is forced low while reset is held so an abandoned access releases the pipeline.
    assign stall = reset && (((state == S_IDLE) && (control_mem_read || control_mem_write))
                             || (state == S_SRAM_WAIT) || (state == S_IO_WAIT));

    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign io_addr    = addr_q;
    assign io_wdata   = wdata_q;

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // Strobes are registered from next_state so they are high exactly while in the wait state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sram_cs   <= 1'b0;
            sram_we   <= 1'b0;
            io_cs     <= 1'b0;
            io_we     <= 1'b0;
            bus_error <= 1'b0;
        end else begin
            sram_cs   <= (next_state == S_SRAM_WAIT);
            sram_we   <= (next_state == S_SRAM_WAIT) && next_dir;
            io_cs     <= (next_state == S_IO_WAIT);
            io_we     <= (next_state == S_IO_WAIT) && next_dir;
            bus_error <= ((state == S_IDLE) && req_both) || timeout_hit;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            dir_q       <= 1'b0;
            io_cnt      <= '0;
            tmo_cnt     <= '0;
            data_loaded <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q  <= address;
                        wdata_q <= data_to_store;
                        dir_q   <= control_mem_write;
                        io_cnt  <= IO_LOAD;
                        tmo_cnt <= '0;
                    end
                end
                S_SRAM_WAIT: begin
                    if (sram_ready) begin
                        if (!dir_q) data_loaded <= sram_rdata;
                    end else if (timeout_hit) begin
                        if (!dir_q) data_loaded <= '1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                S_IO_WAIT: begin
                    io_cnt <= io_cnt - 4'd1;
                    if ((io_cnt == 4'd1) && !dir_q) data_loaded <= io_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/data_bus_controller.md
Name: data_bus_controller

Overview:
- Consumer of the MEM-stage memory control signals (CONTROL_MEM_READ / CONTROL_MEM_WRITE) produced by the signal generation unit.
- Turns each LOAD/STORE into a bus transaction, either to data SRAM (ready handshake) or to the I/O window (fixed wait states).
- Holds the pipeline via stall until the access completes, then returns load data for writeback.

Parameters:
ADDR_WIDTH, 16, data address width
DATA_WIDTH, 8, data width
IO_BASE, 16'h0020, first I/O-window address (inclusive)
IO_LIMIT, 16'h005F, last I/O-window address (inclusive)
IO_WAIT, 2, I/O access cycles (legal range 1..15)
TIMEOUT, 15, SRAM wait cycles before abort (legal range 1..255)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset
control_mem_read  input  1  level; MEM-stage load request
control_mem_write  input  1  level; MEM-stage store request
address  input  ADDR_WIDTH  data address of current LOAD/STORE
data_to_store  input  DATA_WIDTH  store data
data_loaded  output  DATA_WIDTH  last load result, held until next load completes
stall  output  1  freeze pipeline while access is in progress
bus_error  output  1  one-cycle pulse on timeout or illegal request
sram_cs  output  1  SRAM select
sram_we  output  1  SRAM write enable
sram_addr  output  ADDR_WIDTH  SRAM address
sram_wdata  output  DATA_WIDTH  SRAM write data
sram_rdata  input  DATA_WIDTH  SRAM read data, valid with sram_ready
sram_ready  input  1  SRAM access complete
io_cs  output  1  I/O select
io_we  output  1  I/O write enable
io_addr  output  ADDR_WIDTH  I/O address
io_wdata  output  DATA_WIDTH  I/O write data
io_rdata  input  DATA_WIDTH  I/O read data

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM to IDLE; all registered outputs to 0, including data_loaded, the cs/we signals, addr, and wdata.
  - Reset asserted mid-transaction drops sram_cs/io_cs immediately; the access is abandoned.
- FSM states: IDLE, SRAM_WAIT, IO_WAIT, COMPLETE.
- IDLE:
  - Valid request = read XOR write.
  - On a valid request: latch address, data_to_store and direction.
  - Address in [IO_BASE, IO_LIMIT]: go to IO_WAIT, load the wait counter with IO_WAIT.
  - Any other address: go to SRAM_WAIT, clear the timeout counter.
  - Read and write both asserted: no bus access; go to COMPLETE with the error flag set.
  - No request: stay in IDLE.
- stall: combinational.
  - 1 in IDLE when read or write is asserted.
  - 1 in SRAM_WAIT and IO_WAIT.
  - 0 in COMPLETE and in idle IDLE.
- SRAM_WAIT:
  - Registered sram_cs=1, sram_we=dir, sram_addr and sram_wdata from the latches; all held stable for the whole state.
  - sram_ready=1: on a read, capture sram_rdata into data_loaded; go to COMPLETE.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT, go to COMPLETE with the error flag; a read sets data_loaded to all ones.
- IO_WAIT:
  - io_cs=1, io_we=dir, io_addr and io_wdata stable.
  - Counter decrements each cycle. In the cycle it equals 1: on a read, capture io_rdata; go to COMPLETE.
  - io_cs is high for exactly IO_WAIT cycles.
- COMPLETE:
  - All cs/we signals 0; bus_error = error flag (one cycle).
  - Inputs are ignored, even though control signals are still high this cycle; the pipeline advances at this edge.
  - Unconditionally go to IDLE.
- Latency: SRAM access = 2 + (cycles until ready) stall-visible cycles minimum; ready in the first SRAM_WAIT cycle gives stall high for 2 cycles. I/O access stalls for 1+IO_WAIT cycles.
- data_loaded changes only on read completion or timeout; stores never modify it.
- Back-to-back MEM-stage accesses are legal; each starts from IDLE (one COMPLETE bubble between them).
- sram_ready outside SRAM_WAIT is ignored.
- Address comparisons are unsigned, full ADDR_WIDTH; IO_BASE and IO_LIMIT are inclusive boundaries.

Test Plan:
- SRAM load at 16'h0100, sram_ready high on the 3rd SRAM_WAIT cycle with rdata 8'hA5 -> stall high 4 cycles, sram_cs high 3 cycles, data_loaded=8'hA5 once COMPLETE is entered, bus_error=0.
- I/O store at 16'h003F, data 8'h5C, IO_WAIT=2 -> io_cs=io_we=1 for exactly 2 cycles with io_wdata=8'h5C, stall high 3 cycles, data_loaded unchanged.
- Boundary addresses 16'h001F, 16'h0020, 16'h005F, 16'h0060 -> routed to SRAM, IO, IO and SRAM respectively.
- SRAM load, sram_ready never asserted, TIMEOUT=15 -> 15 SRAM_WAIT cycles, sram_cs drops, bus_error one-cycle pulse, data_loaded=8'hFF.
- read and write both asserted in IDLE -> no cs activity, stall high 1 cycle, bus_error pulse, then IDLE.
- reset driven low in the 2nd SRAM_WAIT cycle -> sram_cs=0 and stall=0 without waiting for a clock edge; the next request after release completes normally.
